// File: rtl/test_status_pkg.sv
// Shared definitions for the test status block: FSM state encoding,
// register offsets and the TOHOST value that signals a passing test.
// No ports; imported by the top and the testbench.
package test_status_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [4:0] ADDR_TOHOST  = 5'h00;
  localparam logic [4:0] ADDR_LIMIT   = 5'h04;
  localparam logic [4:0] ADDR_STATUS  = 5'h08;
  localparam logic [4:0] ADDR_CYCLE   = 5'h0C;
  localparam logic [4:0] ADDR_CONSOLE = 5'h10;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/test_status_if.sv
// Register bus plus console byte stream of the test status block.
// slave: DUT side (takes requests, drives read data and console bytes).
// master: host/bench side (issues requests, sinks console bytes).
interface test_status_if;
  logic        bus_req;
  logic        bus_write;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport slave (
    input  bus_req, bus_write, bus_addr, bus_wdata, con_ready,
    output bus_ready, bus_rvalid, bus_rdata, con_valid, con_data
  );

  modport master (
    output bus_req, bus_write, bus_addr, bus_wdata, con_ready,
    input  bus_ready, bus_rvalid, bus_rdata, con_valid, con_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pop_data shows the head (0 when empty), zero read latency.
// Ports: push/push_data in, pop/pop_data out, full/empty flags.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Gate the head so nothing stale leaks out after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/test_status.sv
// Test-status block: TOHOST pass/fail, watchdog timeout, cycle counter, console FIFO.
// Ports: clk, rst_b, bus (register bus + console stream), test_* status outputs.
// Reads answer one cycle after acceptance; CONSOLE writes stall while the FIFO is full.
module test_status
  import test_status_pkg::*;
#(
  parameter int unsigned DEFAULT_TIMEOUT = 1000,
  parameter int unsigned CON_DEPTH       = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  test_status_if.slave  bus,
  output logic          test_done,
  output logic          test_pass,
  output logic          test_fail,
  output logic          test_timeout,
  output logic [30:0]   test_num
);

  state_t      state, next_state;
  logic [31:0] cycle_cnt;
  logic [31:0] wd_cnt;
  logic [31:0] timeout_limit;
  logic [31:0] rd_mux;
  logic        fifo_full, fifo_empty;
  logic        accept, wr_acc, rd_acc;
  logic        tohost_wr, limit_wr, con_push, con_pop;
  logic        wd_expire;

  // Only a CONSOLE write can be held off; everything else is taken at once.
  assign bus.bus_ready = !(bus.bus_req && bus.bus_write &&
                           (bus.bus_addr == ADDR_CONSOLE) && fifo_full);
  assign accept    = bus.bus_req && bus.bus_ready;
  assign wr_acc    = accept && bus.bus_write;
  assign rd_acc    = accept && !bus.bus_write;
  assign tohost_wr = wr_acc && (bus.bus_addr == ADDR_TOHOST);
  assign limit_wr  = wr_acc && (bus.bus_addr == ADDR_LIMIT);
  assign con_push  = wr_acc && (bus.bus_addr == ADDR_CONSOLE);
  assign con_pop   = bus.con_valid && bus.con_ready;
  assign wd_expire = (timeout_limit != 32'd0) && (wd_cnt == timeout_limit - 32'd1);

  always_comb begin
    rd_mux = 32'd0;
    case (bus.bus_addr)
      ADDR_LIMIT:  rd_mux = timeout_limit;
      ADDR_STATUS: rd_mux = {28'd0, fifo_empty, fifo_full, state};
      ADDR_CYCLE:  rd_mux = cycle_cnt;
      default:     rd_mux = 32'd0;
    endcase
  end

  // An odd TOHOST write takes priority over a watchdog expiry in the same
  // cycle; an even write is ignored and so does not mask the expiry.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (tohost_wr && bus.bus_wdata[0]) begin
          next_state = (bus.bus_wdata == TOHOST_PASS) ? ST_PASS : ST_FAIL;
        end else if (wd_expire) begin
          next_state = ST_TIMEOUT;
        end
      end
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= ST_RUN;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_fail    <= 1'b0;
      test_timeout <= 1'b0;
      test_num     <= '0;
    end else begin
      state        <= next_state;
      test_done    <= (next_state != ST_RUN);
      test_pass    <= (next_state == ST_PASS);
      test_fail    <= (next_state == ST_FAIL);
      test_timeout <= (next_state == ST_TIMEOUT);
      if (state == ST_RUN && next_state == ST_FAIL) begin
        test_num <= bus.bus_wdata[31:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cycle_cnt     <= 32'd0;
      wd_cnt        <= 32'd0;
      timeout_limit <= 32'(DEFAULT_TIMEOUT);
      bus.bus_rvalid <= 1'b0;
      bus.bus_rdata  <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (limit_wr) begin
        timeout_limit <= bus.bus_wdata;
        wd_cnt        <= 32'd0;
      end else if (state == ST_RUN) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
      bus.bus_rvalid <= rd_acc;
      bus.bus_rdata  <= rd_acc ? rd_mux : 32'd0;
    end
  end

  assign bus.con_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (con_push),
    .push_data (bus.bus_wdata[7:0]),
    .pop       (con_pop),
    .pop_data  (bus.con_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_test_status.sv
// Directed bench for test_status: register vector table plus sequences for
// pass/fail, watchdog timing, console stall/drain and asynchronous reset.
module tb_test_status;
  import test_status_pkg::*;

  localparam int unsigned DEF_TO = 1000;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        test_done, test_pass, test_fail, test_timeout;
  logic [30:0] test_num;

  int checks = 0;
  int errors = 0;

  test_status_if bus_if();

  test_status #(
    .DEFAULT_TIMEOUT (DEF_TO),
    .CON_DEPTH       (4)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .bus          (bus_if),
    .test_done    (test_done),
    .test_pass    (test_pass),
    .test_fail    (test_fail),
    .test_timeout (test_timeout),
    .test_num     (test_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_write = 1'b1;
    bus_if.bus_addr = a;   bus_if.bus_wdata = d;
    @(posedge clk); #1;
    bus_if.bus_req = 1'b0; bus_if.bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_write = 1'b0; bus_if.bus_addr = a;
    @(posedge clk); #1;
    v = bus_if.bus_rvalid; d = bus_if.bus_rdata;
    bus_if.bus_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; bus_if.bus_req = 1'b0; bus_if.con_ready = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, rd2;
    logic        rv;
    int          n;

    bus_if.bus_req = 1'b0; bus_if.bus_write = 1'b0;
    bus_if.bus_addr = '0;  bus_if.bus_wdata = '0;
    bus_if.con_ready = 1'b0;

    vecs[0]  = '{1'b0, ADDR_LIMIT,   32'h0,        32'd1000};
    vecs[1]  = '{1'b1, ADDR_LIMIT,   32'h1234,     32'h0};
    vecs[2]  = '{1'b0, ADDR_LIMIT,   32'h0,        32'h1234};
    vecs[3]  = '{1'b0, ADDR_STATUS,  32'h0,        32'h8};
    vecs[4]  = '{1'b0, 5'h14,        32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'h06,        32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'h14,        32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{1'b1, 5'h05,        32'hDEAD,     32'h0};
    vecs[8]  = '{1'b0, ADDR_LIMIT,   32'h0,        32'h1234};
    vecs[9]  = '{1'b1, ADDR_TOHOST,  32'h2,        32'h0};
    vecs[10] = '{1'b0, ADDR_STATUS,  32'h0,        32'h8};

    // Reset values while rst_b is held low
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   {31'd0, test_done},         32'd0);
    check("rst_flags",  {29'd0, test_pass, test_fail, test_timeout}, 32'd0);
    check("rst_num",    {1'b0, test_num},           32'd0);
    check("rst_cvalid", {31'd0, bus_if.con_valid},  32'd0);
    check("rst_cdata",  {24'd0, bus_if.con_data},   32'd0);
    check("rst_rvalid", {31'd0, bus_if.bus_rvalid}, 32'd0);
    check("rst_rdata",  bus_if.bus_rdata,           32'd0);
    check("rst_ready",  {31'd0, bus_if.bus_ready},  32'd1);
    @(negedge clk);
    rst_b = 1'b1;

    // Register table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus_if.bus_req = 1'b1; bus_if.bus_write = vecs[i].wr;
      bus_if.bus_addr = vecs[i].addr; bus_if.bus_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_ready", i), {31'd0, bus_if.bus_ready}, 32'd1);
      @(posedge clk); #1;
      bus_if.bus_req = 1'b0;
      check($sformatf("vec%0d_rvalid", i), {31'd0, bus_if.bus_rvalid}, {31'd0, !vecs[i].wr});
      check($sformatf("vec%0d_rdata", i), bus_if.bus_rdata, vecs[i].exp_rdata);
    end
    check("even_tohost_done", {31'd0, test_done}, 32'd0);

    // Pass
    do_reset();
    bus_wr(ADDR_TOHOST, 32'd1);
    check("pass_pass", {31'd0, test_pass}, 32'd1);
    check("pass_done", {31'd0, test_done}, 32'd1);
    bus_rd(ADDR_STATUS, rd, rv);
    check("pass_status", {30'd0, rd[1:0]}, 32'd1);

    // Fail, then sticky
    do_reset();
    bus_wr(ADDR_TOHOST, 32'h0000000B);
    check("fail_fail", {31'd0, test_fail}, 32'd1);
    check("fail_num",  {1'b0, test_num},   32'd5);
    bus_wr(ADDR_TOHOST, 32'd1);
    check("fail_sticky", {30'd0, test_fail, test_pass}, 32'h2);
    check("fail_num_keep", {1'b0, test_num}, 32'd5);

    // Watchdog: rises on the 20th edge after the limit write is accepted
    do_reset();
    bus_wr(ADDR_LIMIT, 32'd20);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 19) check("wd_early", {31'd0, test_timeout}, 32'd0);
      if (k == 20) begin
        check("wd_timeout", {31'd0, test_timeout}, 32'd1);
        check("wd_done",    {31'd0, test_done},    32'd1);
      end
    end

    // TOHOST write in the expiry cycle wins
    do_reset();
    bus_wr(ADDR_LIMIT, 32'd20);
    repeat (19) @(posedge clk);
    bus_wr(ADDR_TOHOST, 32'd1);
    check("race_flags", {30'd0, test_pass, test_timeout}, 32'h2);

    // Limit 0 disables the watchdog
    do_reset();
    bus_wr(ADDR_LIMIT, 32'd0);
    repeat (10000) @(posedge clk);
    #1;
    check("wd_off", {30'd0, test_done, test_timeout}, 32'd0);

    // Console stall and ordered drain
    do_reset();
    for (int b = 0; b < 4; b++) bus_wr(ADDR_CONSOLE, 32'h41 + b);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_write = 1'b1;
    bus_if.bus_addr = ADDR_CONSOLE; bus_if.bus_wdata = 32'h45;
    #1;
    check("con_stall", {31'd0, bus_if.bus_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("con_stall_hold", {31'd0, bus_if.bus_ready}, 32'd0);
    check("con_head", {24'd0, bus_if.con_data}, 32'h41);
    bus_if.con_ready = 1'b1;
    fork
      begin
        int m;
        m = 0;
        while (!bus_if.bus_ready && m < 50) begin @(negedge clk); m++; end
        @(posedge clk); #1;
        bus_if.bus_req = 1'b0; bus_if.bus_write = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          int w;
          w = 0;
          while (!(bus_if.con_valid && bus_if.con_ready) && w < 50) begin @(negedge clk); w++; end
          check($sformatf("drain_byte%0d", i), {24'd0, bus_if.con_data}, 32'h41 + i);
          @(negedge clk);
        end
      end
    join
    bus_rd(ADDR_STATUS, rd, rv);
    check("con_status_after", rd, 32'h8);

    // CYCLE difference, then asynchronous reset mid-drain
    do_reset();
    bus_rd(ADDR_CYCLE, rd, rv);
    repeat (2) @(posedge clk);
    bus_rd(ADDR_CYCLE, rd2, rv);
    check("cycle_delta", rd2 - rd, 32'd3);
    for (int b = 0; b < 3; b++) bus_wr(ADDR_CONSOLE, 32'h61 + b);
    bus_if.con_ready = 1'b1;
    bus_rd(ADDR_CYCLE, rd, rv);
    check("mid_rvalid", {31'd0, rv}, 32'd1);
    check("mid_cvalid", {31'd0, bus_if.con_valid}, 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("arst_cvalid", {31'd0, bus_if.con_valid}, 32'd0);
    check("arst_cdata",  {24'd0, bus_if.con_data},  32'd0);
    check("arst_rvalid", {31'd0, bus_if.bus_rvalid}, 32'd0);
    check("arst_rdata",  bus_if.bus_rdata, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
